// File: rtl/pri_decoder.sv
// Priority decoder: expands a bit position into a thermometer mask (bits p..0 set) or a one-hot word.
// Two-stage valid/ready pipeline; positions at or beyond WIDTH produce a zero word with out_err set.
module pri_decoder #(
    parameter int WIDTH     = 56,
    parameter int WIDTH_LOG = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_LOG-1:0] in_idx,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic [15:0]          out_count
);

    localparam int SPAN = 1 << WIDTH_LOG;

    // Mirror of the encoder tree: each idx bit picks the upper or lower half of a doubling span.
    // In thermometer mode the lower half is filled with ones whenever the upper half is selected.
    function automatic logic [SPAN-1:0] tree_mask(input logic [WIDTH_LOG-1:0] idx,
                                                  input logic                 mode);
        logic [SPAN-1:0] m;
        logic [SPAN-1:0] nxt;
        int              half;
        m    = '0;
        m[0] = 1'b1;
        for (int w = 0; w < WIDTH_LOG; w++) begin
            half = 1 << w;
            nxt  = '0;
            for (int j = 0; j < SPAN; j++) begin
                if (j < 2 * half) begin
                    if (idx[w]) begin
                        if (j >= half) nxt[j] = m[j-half];
                        else           nxt[j] = ~mode;
                    end else if (j < half) begin
                        nxt[j] = m[j];
                    end
                end
            end
            m = nxt;
        end
        return m;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic                 r_s1_valid;
    logic [WIDTH_LOG-1:0] r_s1_idx;
    logic                 r_s1_mode;
    logic                 r_s1_err;
    logic                 r_s2_valid;
    logic [WIDTH-1:0]     r_s2_data;
    logic                 r_s2_err;
    logic [15:0]          r_count;

    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_in_err;
    logic [SPAN-1:0]      w_mask;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
    assign w_accept  = in_valid && in_ready;
    assign w_in_err  = (32'(in_idx) >= WIDTH);
    assign w_mask    = tree_mask(r_s1_idx, r_s1_mode);

    // Stage 1: request capture
    always_ff @(posedge clk) begin
        if (rst)           r_s1_valid <= 1'b0;
        else if (w_accept) r_s1_valid <= 1'b1;
        else if (w_s1_adv) r_s1_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_idx  <= in_idx;
            r_s1_mode <= in_mode;
            r_s1_err  <= w_in_err;
        end
    end

    // Stage 2: decoded output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= r_s1_err ? '0 : w_mask[WIDTH-1:0];
            r_s2_err   <= r_s1_err;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          r_count <= 16'd0;
        else if (r_s2_valid && out_ready) r_count <= sat_inc(r_count);
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_err   = r_s2_err;
    assign out_count = r_count;

endmodule
